// File: rtl/pipe_perf_monitor_pkg.sv
// Shared types and helpers for the pipeline performance monitor.
package perf_pkg;

    // Largest supported number of monitored pipeline stages.
    localparam int unsigned MAX_NSTAGE = 8;

    // End-of-test status, encoded exactly as presented on the status port.
    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_PASS    = 2'b01,
        ST_FAIL    = 2'b10,
        ST_TIMEOUT = 2'b11
    } status_e;

    // Readout select width: NSTAGE valid + NSTAGE stall counters + 1 cycle counter.
    function automatic int unsigned sel_width(input int unsigned nstage);
        return $clog2(2 * nstage + 1);
    endfunction

endpackage

// File: rtl/pipe_perf_monitor_sat_counter.sv
// Saturating up-counter: increments on inc unless held, sticks at all-ones.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         hold,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: advance only when enabled, not held and below saturation.
    always_comb begin
        cnt_d = cnt_q;
        if (inc && !hold && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/pipe_perf_monitor.sv
// Pipeline activity monitor: per-stage valid/stall counters, cycle counter,
// pass/fail PC detection and cycle-budget timeout, with registered readout.
module pipe_perf_monitor
    import perf_pkg::*;
#(
    parameter  int unsigned NSTAGE  = 4,
    parameter  int unsigned CW      = 32,
    parameter  int unsigned XLEN    = 32,
    parameter  int unsigned TIMEOUT = 1000000,
    localparam int unsigned SELW    = sel_width(NSTAGE)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [NSTAGE-1:0] stage_v,
    input  logic [NSTAGE-1:0] stage_stall,
    input  logic              pc_v,
    input  logic [XLEN-1:0]   pc_i,
    input  logic [XLEN-1:0]   pass_pc,
    input  logic [XLEN-1:0]   fail_pc,
    input  logic [SELW-1:0]   cnt_sel,
    output logic [CW-1:0]     cnt_data,
    output logic [1:0]        status,
    output logic              done
);

    // Counter map: [0..NSTAGE-1] valid, [NSTAGE..2*NSTAGE-1] stall, [2*NSTAGE] cycles.
    localparam int unsigned NCNT   = 2 * NSTAGE + 1;
    localparam int unsigned CYC    = 2 * NSTAGE;
    localparam logic [63:0] TO_LAST = (TIMEOUT == 0) ? 64'd0 : (64'(TIMEOUT) - 64'd1);

    status_e         state_q, state_d;
    logic [XLEN-1:0] pass_pc_q, fail_pc_q;
    logic [NCNT-1:0] inc;
    logic            cnt_hold;
    logic            timeout_hit;
    logic [CW-1:0]   cnt_q   [NCNT];
    logic [CW-1:0]   cnt_nxt [NCNT];
    logic [CW-1:0]   cnt_data_d, cnt_data_q;

    assign inc      = {1'b1, stage_stall, stage_v};
    assign cnt_hold = (state_q != ST_RUN) || !enable;

    for (genvar g = 0; g < NCNT; g++) begin : g_cnt
        sat_counter #(.W(CW)) u_cnt (
            .clk   (clk),
            .reset (reset),
            .inc   (inc[g]),
            .hold  (cnt_hold),
            .q     (cnt_q[g])
        );
    end

    // Cycle count is widened so budgets beyond 2^CW never alias to a small count.
    assign timeout_hit = (TIMEOUT != 0) && enable && (64'(cnt_q[CYC]) == TO_LAST);

    // Next state: FAIL beats PASS beats TIMEOUT; terminal states are sticky.
    always_comb begin
        state_d = state_q;
        if (state_q == ST_RUN) begin
            if (pc_v && (pc_i == fail_pc_q)) begin
                state_d = ST_FAIL;
            end else if (pc_v && (pc_i == pass_pc_q)) begin
                state_d = ST_PASS;
            end else if (timeout_hit) begin
                state_d = ST_TIMEOUT;
            end
        end
    end

    // State register; end-of-test addresses are captured throughout reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_RUN;
            pass_pc_q <= pass_pc;
            fail_pc_q <= fail_pc;
        end else begin
            state_q   <= state_d;
        end
    end

    // Readout mux works on post-increment values so the registered output
    // reflects any update made in the same cycle the select was presented.
    always_comb begin
        cnt_data_d = '0;
        for (int unsigned i = 0; i < NCNT; i++) begin
            cnt_nxt[i] = cnt_q[i];
            if (inc[i] && !cnt_hold && (cnt_q[i] != '1)) begin
                cnt_nxt[i] = cnt_q[i] + CW'(1);
            end
            if (cnt_sel == SELW'(i)) begin
                cnt_data_d = cnt_nxt[i];
            end
        end
    end

    // Registered readout.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_data_q <= '0;
        end else begin
            cnt_data_q <= cnt_data_d;
        end
    end

    assign cnt_data = cnt_data_q;
    assign status   = state_q;
    assign done     = (state_q != ST_RUN);

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Scoreboard bench: three monitor instances share stimulus.
//   dut 0: CW=32, TIMEOUT=20   dut 1: CW=32, TIMEOUT=0   dut 2: CW=4, TIMEOUT=0
module tb_pipe_perf_monitor;

    localparam int unsigned NS   = 4;
    localparam int unsigned SELW = 4;
    localparam int K_STATUS = 0;
    localparam int K_DONE   = 1;
    localparam int K_DATA   = 2;

    logic            clk = 1'b0;
    logic            reset, enable, pc_v;
    logic [NS-1:0]   stage_v, stage_stall;
    logic [31:0]     pc_i, pass_pc, fail_pc;
    logic [SELW-1:0] cnt_sel;

    logic [31:0] data_a, data_b;
    logic [3:0]  data_c;
    logic [1:0]  status_a, status_b, status_c;
    logic        done_a, done_b, done_c;

    always #5 clk = ~clk;

    pipe_perf_monitor #(.NSTAGE(NS), .CW(32), .XLEN(32), .TIMEOUT(20)) u_dut_a (
        .clk(clk), .reset(reset), .enable(enable), .stage_v(stage_v),
        .stage_stall(stage_stall), .pc_v(pc_v), .pc_i(pc_i), .pass_pc(pass_pc),
        .fail_pc(fail_pc), .cnt_sel(cnt_sel), .cnt_data(data_a),
        .status(status_a), .done(done_a));

    pipe_perf_monitor #(.NSTAGE(NS), .CW(32), .XLEN(32), .TIMEOUT(0)) u_dut_b (
        .clk(clk), .reset(reset), .enable(enable), .stage_v(stage_v),
        .stage_stall(stage_stall), .pc_v(pc_v), .pc_i(pc_i), .pass_pc(pass_pc),
        .fail_pc(fail_pc), .cnt_sel(cnt_sel), .cnt_data(data_b),
        .status(status_b), .done(done_b));

    pipe_perf_monitor #(.NSTAGE(NS), .CW(4), .XLEN(32), .TIMEOUT(0)) u_dut_c (
        .clk(clk), .reset(reset), .enable(enable), .stage_v(stage_v),
        .stage_stall(stage_stall), .pc_v(pc_v), .pc_i(pc_i), .pass_pc(pass_pc),
        .fail_pc(fail_pc), .cnt_sel(cnt_sel), .cnt_data(data_c),
        .status(status_c), .done(done_c));

    typedef struct packed {
        int          cyc;
        int          dut;
        int          kind;
        int          tst;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    int          tst   = 0;
    logic [31:0] act;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] get(input int d, input int k);
        case (k)
            K_STATUS: return (d == 0) ? {30'b0, status_a} : (d == 1) ? {30'b0, status_b} : {30'b0, status_c};
            K_DONE:   return (d == 0) ? {31'b0, done_a}   : (d == 1) ? {31'b0, done_b}   : {31'b0, done_c};
            default:  return (d == 0) ? data_a            : (d == 1) ? data_b            : {28'b0, data_c};
        endcase
    endfunction

    function automatic string kname(input int k);
        case (k)
            K_STATUS: return "status";
            K_DONE:   return "done";
            default:  return "cnt_data";
        endcase
    endfunction

    // Monitor: compare every expectation due in this cycle, away from the clock edge.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                act = get(sb[i].dut, sb[i].kind);
                n_cmp++;
                if ((sb[i].cyc != cyc) || (act !== sb[i].val)) begin
                    n_bad++;
                    $display("FAIL test%0d dut%0d %s @cyc %0d: actual=%0d required=%0d",
                             sb[i].tst, sb[i].dut, kname(sb[i].kind), sb[i].cyc, act, sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect1(input int d, input int dut, input int k, input logic [31:0] v);
        exp_t e;
        e.cyc = cyc + d; e.dut = dut; e.kind = k; e.tst = tst; e.val = v;
        sb.push_back(e);
    endtask

    task automatic expect_all(input int d, input int k, input logic [31:0] v);
        for (int j = 0; j < 3; j++) expect1(d, j, k, v);
    endtask

    task automatic do_reset(input logic [31:0] p, input logic [31:0] f);
        reset = 1'b1; enable = 1'b0; pc_v = 1'b0; pc_i = '0;
        stage_v = '0; stage_stall = '0; cnt_sel = '0;
        pass_pc = p; fail_pc = f;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        // Test 1: PASS at pc hit in cycle 10; cycle count 11 and frozen.
        tst = 1;
        do_reset(32'h100, 32'h200);
        expect_all(0, K_STATUS, 0);
        expect_all(0, K_DONE, 0);
        expect_all(0, K_DATA, 0);
        enable = 1'b1;
        repeat (10) step();
        expect_all(0, K_STATUS, 0);
        pc_v = 1'b1; pc_i = 32'h100;
        expect_all(1, K_STATUS, 1);
        expect_all(1, K_DONE, 1);
        step();
        pc_v = 1'b0; cnt_sel = 4'd8;
        expect_all(1, K_DATA, 11);
        repeat (4) step();
        expect_all(0, K_DATA, 11);
        expect_all(0, K_STATUS, 1);
        step();

        // Test 2a: pass_pc == fail_pc -> FAIL wins.
        tst = 2;
        do_reset(32'h80, 32'h80);
        enable = 1'b1;
        step();
        pc_v = 1'b1; pc_i = 32'h80;
        expect_all(1, K_STATUS, 2);
        step();
        pc_v = 1'b0;
        step();

        // Test 2b: pass hit in the cycle the timeout would fire -> PASS.
        tst = 3;
        do_reset(32'h100, 32'h200);
        enable = 1'b1;
        repeat (19) step();
        expect1(0, 0, K_STATUS, 0);
        pc_v = 1'b1; pc_i = 32'h100;
        expect_all(1, K_STATUS, 1);
        step();
        pc_v = 1'b0;
        step();

        // Test 3: TIMEOUT=20 fires after 20 counted cycles; TIMEOUT=0 never does.
        tst = 4;
        do_reset(32'h100, 32'h200);
        enable = 1'b1;
        repeat (19) step();
        expect1(0, 0, K_STATUS, 0);
        expect1(1, 0, K_STATUS, 3);
        expect1(1, 0, K_DONE, 1);
        repeat (981) step();
        enable = 1'b0; cnt_sel = 4'd8;
        expect1(0, 1, K_STATUS, 0);
        expect1(0, 1, K_DONE, 0);
        expect1(0, 2, K_STATUS, 0);
        expect1(1, 0, K_DATA, 20);
        expect1(1, 1, K_DATA, 1000);
        expect1(1, 2, K_DATA, 15);
        step();
        step();

        // Test 4a: stage_v[1] for 20 cycles; CW=4 instance saturates at 15.
        tst = 5;
        do_reset(32'h100, 32'h200);
        enable = 1'b1; stage_v = 4'b0010;
        repeat (20) step();
        stage_v = '0; enable = 1'b0; cnt_sel = 4'd1;
        expect1(1, 0, K_DATA, 20);
        expect1(1, 1, K_DATA, 20);
        expect1(1, 2, K_DATA, 15);
        step();
        cnt_sel = 4'd0;
        expect_all(1, K_DATA, 0);
        step();

        // Test 4b: enable toggling 1/0 for 10 cycles -> 5 counted cycles.
        tst = 6;
        do_reset(32'h100, 32'h200);
        for (int i = 0; i < 10; i++) begin
            enable = ((i % 2) == 0);
            step();
        end
        enable = 1'b0; cnt_sel = 4'd8;
        expect_all(1, K_DATA, 5);
        step();

        // Test 5: simultaneous valid+stall on stage 2; same-cycle readout; out-of-range select.
        tst = 7;
        do_reset(32'h100, 32'h200);
        enable = 1'b1; stage_v = 4'b0100; stage_stall = 4'b0100; cnt_sel = 4'd6;
        expect_all(1, K_DATA, 1);
        step();
        expect_all(1, K_DATA, 2);
        step();
        expect_all(1, K_DATA, 3);
        step();
        stage_v = '0; stage_stall = '0; enable = 1'b0; cnt_sel = 4'd2;
        expect_all(1, K_DATA, 3);
        step();
        cnt_sel = 4'd9;
        expect_all(1, K_DATA, 0);
        step();
        cnt_sel = 4'd6;
        expect_all(1, K_DATA, 3);
        step();
        cnt_sel = 4'd15;
        expect_all(1, K_DATA, 0);
        step();

        // Test 6: reset while in PASS -> RUN, zeroed counters, new pass_pc honoured.
        tst = 8;
        do_reset(32'h100, 32'h200);
        enable = 1'b1; stage_v = 4'b0001;
        step();
        step();
        pc_v = 1'b1; pc_i = 32'h100;
        expect_all(1, K_STATUS, 1);
        step();
        pc_v = 1'b0; reset = 1'b1; pass_pc = 32'h300; cnt_sel = 4'd8;
        expect_all(1, K_STATUS, 0);
        expect_all(1, K_DONE, 0);
        expect_all(1, K_DATA, 0);
        step();
        reset = 1'b0;
        expect_all(1, K_DATA, 1);
        step();
        pc_v = 1'b1; pc_i = 32'h100;
        expect_all(1, K_STATUS, 0);
        step();
        pc_i = 32'h300;
        expect_all(1, K_STATUS, 1);
        expect_all(1, K_DONE, 1);
        step();
        pc_v = 1'b0;

        // Drain the scoreboard with a bounded wait.
        repeat (5) step();
        if (sb.size() != 0) begin
            $display("FAIL drain: actual=%0d pending expectations, required=0", sb.size());
            n_cmp += sb.size();
            n_bad += sb.size();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pipe_perf_monitor.md
Name: pipe_perf_monitor

Overview:
- Synthesizable, parametrised pipeline activity monitor with end-of-test detection.
- Counts valid instructions and stalls per pipeline stage, plus total cycles.
- Detects pass/fail PC hits and a cycle-budget timeout.
- Sits beside the cpu core and is driven by stage-valid and stall strobes tapped from it. The count readout and status are visible to both the simulation top and on-chip debug logic.

Parameters:
- NSTAGE, 4, number of monitored pipeline stages (stage 0 = issue/fetch), 1..8
- CW, 32, counter width in bits
- XLEN, 32, PC width
- TIMEOUT, 1000000, cycle budget before timeout status; 0 disables the timeout

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- enable  in  1  counting enable; while low all counters hold
- stage_v  in  NSTAGE  per-stage "instruction advanced" strobe (already qualified by the stage's own stall)
- stage_stall  in  NSTAGE  per-stage stall strobe
- pc_v  in  1  pc_i carries a valid issued instruction
- pc_i  in  XLEN  PC of the issued instruction
- pass_pc  in  XLEN  pass address; captured while reset is high
- fail_pc  in  XLEN  fail address; captured while reset is high
- cnt_sel  in  SELW  readout select: 0..NSTAGE-1 valid counts, NSTAGE..2*NSTAGE-1 stall counts, 2*NSTAGE cycle count
- cnt_data  out  CW  selected counter value, registered
- status  out  2  00 RUN, 01 PASS, 10 FAIL, 11 TIMEOUT
- done  out  1  high in any terminal state

SELW = $clog2(2*NSTAGE+1).

Behaviour:
- Reset:
  - All outputs and counters go to zero and the FSM enters RUN.
  - pass_pc and fail_pc are registered on every cycle that reset is high.
  - Reset asserted mid-run immediately returns the block to RUN with zeroed counters.
- FSM states are RUN, PASS, FAIL, TIMEOUT. PASS, FAIL and TIMEOUT are sticky until reset.
- Transitions out of RUN, evaluated every cycle regardless of enable:
  - pc_v && pc_i==fail_pc_q → FAIL.
  - Otherwise pc_v && pc_i==pass_pc_q → PASS.
  - Otherwise TIMEOUT!=0 && cycle count == TIMEOUT-1 && enable → TIMEOUT.
  - Priority is FAIL > PASS > TIMEOUT; if pass_pc==fail_pc, FAIL wins.
- Counting happens only in RUN with enable=1:
  - Cycle counter increments by 1 each cycle.
  - Valid counter k increments when stage_v[k]=1.
  - Stall counter k increments when stage_stall[k]=1.
  - stage_v[k] and stage_stall[k] both high in one cycle → both counters increment; no error is flagged.
  - All counters saturate at 2^CW-1 and never wrap.
  - Strobes in the cycle that causes the transition to a terminal state are still counted. From the next cycle on, counters freeze.
- status and done update one cycle after the triggering input; done = (status != RUN).
- Readout:
  - cnt_data is registered with 1-cycle latency from cnt_sel.
  - It remains readable in all states, including while the counters are frozen.
  - cnt_sel > 2*NSTAGE → cnt_data = 0.
  - If the selected counter changes in cycle t, cnt_data shows the post-increment value at t+1.
- Total latency from a pc_v hit to done=1 is 1 cycle.

Decomposition:
- Package perf_pkg holds:
  - the status_e enum (RUN, PASS, FAIL, TIMEOUT; 2 bits)
  - the SELW helper function
  - the MAX_NSTAGE=8 constant
- Sub-module sat_counter (params W; ports clk, reset, inc, hold, q) provides a saturating increment. It is instantiated 2*NSTAGE+1 times via generate.
- The FSM and readout mux live in pipe_perf_monitor.

Test Plan:
1. Reset with pass_pc=0x100, fail_pc=0x200, then drive pc_v with pc_i=0x100 at cycle 10 → status=01 and done=1 at cycle 11; cycle count reads 11 and stays 11 afterwards.
2. pass_pc=fail_pc=0x80 and pc_i=0x80 issued → status=10 (FAIL priority). Separately, a pc hit in the same cycle the timeout fires → PASS/FAIL, not TIMEOUT.
3. TIMEOUT=20, enable=1, no pc hits → status=11 after exactly 20 counted cycles. TIMEOUT=0 with 1000 cycles → status stays 00.
4. CW=4, stage_v[1] held high for 20 cycles → valid count 1 reads 15 (saturated). With enable toggling 1/0 every cycle for 10 cycles → cycle count 5.
5. stage_v[2]=stage_stall[2]=1 for 3 cycles → both counters read 3. cnt_sel=2*NSTAGE+1 → cnt_data=0 one cycle later.
6. Reach PASS, then assert reset for 1 cycle mid-terminal → next cycle status=00, all counters 0, new pass_pc captured and honoured.
